// File: rtl/watch_pkg.sv
// Shared stopwatch types and default field moduli.
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam int unsigned MSEC_MAX_D = 1000;
    localparam int unsigned SEC_MAX_D  = 60;
    localparam int unsigned MIN_MAX_D  = 60;
    localparam int unsigned HOUR_MAX_D = 24;

endpackage

// File: rtl/tick_mod_counter.sv
// Modulo-N tick counter with synchronous clear and ripple carry.
//  clk       : system clock
//  reset     : asynchronous active-low reset
//  tick_in   : count enable (one clk wide)
//  clear     : synchronous clear, overrides tick_in
//  count     : registered count, 0..N-1
//  carry_out : combinational, high when tick_in arrives at count N-1
module tick_mod_counter #(
    parameter int unsigned N = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_in,
    input  logic                   clear,
    output logic [$clog2(N)-1:0]   count,
    output logic                   carry_out
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic at_last;
    assign at_last   = (count == LAST);
    assign carry_out = tick_in & at_last;

    // Count register: clear has priority, wrap to zero after LAST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick_in) begin
            count <= at_last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timebase: run/pause/clear FSM gating a hour:min:sec:msec cascade.
//  clk       : system clock
//  reset     : asynchronous active-low reset
//  clk_msec  : 1 ms tick, one clk wide
//  btn_run   : run/pause toggle pulse
//  btn_clear : clear request pulse (acts only in PAUSE)
//  msec/sec/min/hour : elapsed time fields
//  running   : high while in RUN
//  rollover  : one-clk pulse when the full count wraps to zero
module stopwatch_time_counter
    import watch_pkg::*;
#(
    parameter int unsigned MSEC_MAX = MSEC_MAX_D,
    parameter int unsigned SEC_MAX  = SEC_MAX_D,
    parameter int unsigned MIN_MAX  = MIN_MAX_D,
    parameter int unsigned HOUR_MAX = HOUR_MAX_D
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_msec,
    input  logic                          btn_run,
    input  logic                          btn_clear,
    output logic [$clog2(MSEC_MAX)-1:0]   msec,
    output logic [$clog2(SEC_MAX)-1:0]    sec,
    output logic [$clog2(MIN_MAX)-1:0]    min,
    output logic [$clog2(HOUR_MAX)-1:0]   hour,
    output logic                          running,
    output logic                          rollover
);

    sw_state_t state;
    sw_state_t state_next;

    logic run_tick;
    logic clear_req;
    logic msec_carry;
    logic sec_carry;
    logic min_carry;
    logic hour_carry;

    // Gating uses the registered state, so the pausing cycle still counts
    // and the starting/resuming cycle does not.
    assign run_tick  = clk_msec & (state == RUN);
    assign clear_req = btn_clear & (state == PAUSE);

    // State, running flag and rollover pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            rollover <= 1'b0;
        end else begin
            state    <= state_next;
            running  <= (state_next == RUN);
            rollover <= hour_carry;
        end
    end

    // Next-state logic; clear beats run in PAUSE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (btn_run) state_next = RUN;
            RUN:     if (btn_run) state_next = PAUSE;
            PAUSE: begin
                if (btn_clear)    state_next = IDLE;
                else if (btn_run) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    tick_mod_counter #(.N(MSEC_MAX)) u_msec (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (run_tick),
        .clear     (clear_req),
        .count     (msec),
        .carry_out (msec_carry)
    );

    tick_mod_counter #(.N(SEC_MAX)) u_sec (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (msec_carry),
        .clear     (clear_req),
        .count     (sec),
        .carry_out (sec_carry)
    );

    tick_mod_counter #(.N(MIN_MAX)) u_min (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (sec_carry),
        .clear     (clear_req),
        .count     (min),
        .carry_out (min_carry)
    );

    tick_mod_counter #(.N(HOUR_MAX)) u_hour (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (min_carry),
        .clear     (clear_req),
        .count     (hour),
        .carry_out (hour_carry)
    );

endmodule
